rand_req_arbiter: RTL and testbench

//  Shares one 8-bit XNOR LFSR random source among N enemy-tank AI requesters.

---
 rtl/tank_pkg.sv | 50 +++++
 rtl/lfsr_step8.sv | 35 +++
 rtl/rand_req_arbiter.sv | 169 ++++++++++++++++
 tb/tb_rand_req_arbiter.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// -----------------------------------------------------------------------------
// tank_pkg
// Shared types and helpers for the enemy-tank random source.
//   ra_state_t      : arbiter FSM state encoding
//   RAND_W          : width of the random byte
//   RAND_LOCKUP     : the one state an XNOR LFSR can never leave
//   lfsr_next       : one free-running XNOR LFSR step
//   lfsr_seed_guard : maps the lock-up value to a safe seed
//   lfsr_d          : full next-state (seed load overrides the step)
// -----------------------------------------------------------------------------
package tank_pkg;

    typedef enum logic [1:0] {
        RA_IDLE  = 2'b00,
        RA_WAIT  = 2'b01,
        RA_GRANT = 2'b10
    } ra_state_t;

    localparam int RAND_W = 8;
    localparam logic [RAND_W-1:0] RAND_LOCKUP = 8'hFF;

    // Taps at bits 7 and 2, XNOR feedback shifted in at the LSB.
    function automatic logic [RAND_W-1:0] lfsr_next(input logic [RAND_W-1:0] s);
        return {s[6:0], ~(s[7] ^ s[2])};
    endfunction

    // All-ones would freeze an XNOR LFSR, so it is replaced by all-zeros.
    function automatic logic [RAND_W-1:0] lfsr_seed_guard(input logic [RAND_W-1:0] v);
        logic [RAND_W-1:0] r;
        if (v == RAND_LOCKUP) begin
            r = {RAND_W{1'b0}};
        end else begin
            r = v;
        end
        return r;
    endfunction

    function automatic logic [RAND_W-1:0] lfsr_d(input logic              load,
                                                 input logic [RAND_W-1:0] load_val,
                                                 input logic [RAND_W-1:0] s);
        logic [RAND_W-1:0] r;
        if (load) begin
            r = lfsr_seed_guard(load_val);
        end else begin
            r = lfsr_next(s);
        end
        return r;
    endfunction

endpackage

// File: rtl/lfsr_step8.sv
// -----------------------------------------------------------------------------
// lfsr_step8
// 8-bit XNOR LFSR register, free-running, reset to 8'h00. A load replaces
// the step for that cycle; a lock-up seed (8'hFF) is loaded as 8'h00.
// Ports:
//   Clk      in  1       clock
//   Reset_n  in  1       asynchronous active-low reset
//   load     in  1       load load_val instead of stepping
//   load_val in  RAND_W  seed value
//   q        out RAND_W  current LFSR state (registered)
// -----------------------------------------------------------------------------
module lfsr_step8
    import tank_pkg::*;
(
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              load,
    input  logic [RAND_W-1:0] load_val,
    output logic [RAND_W-1:0] q
);

    logic [RAND_W-1:0] q_r;

    // LFSR state register: step every cycle or take a guarded seed.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            q_r <= {RAND_W{1'b0}};
        end else begin
            q_r <= lfsr_d(load, load_val, q_r);
        end
    end

    assign q = q_r;

endmodule

// File: rtl/rand_req_arbiter.sv
// -----------------------------------------------------------------------------
// rand_req_arbiter
// Shares one 8-bit XNOR LFSR among N_REQ enemy-tank AI requesters. A request
// is picked round-robin, the LFSR runs for STEPS cycles to decorrelate, then
// the winner gets one random byte with a one-cycle one-hot valid pulse.
// Parameters:
//   N_REQ  number of requesters (2..8)
//   STEPS  cycles between grant decision and data delivery (1..255)
// Ports:
//   Clk        in  1      clock
//   Reset_n    in  1      asynchronous active-low reset
//   req        in  N_REQ  level request, held until own rsp_valid bit is seen
//   seed_load  in  1      (RAND_SEED_EN only) load seed into the LFSR
//   seed       in  8      (RAND_SEED_EN only) seed value, 8'hFF loads 8'h00
//   rsp_valid  out N_REQ  one-hot, one-cycle data-valid pulse
//   rsp_data   out 8      random byte while rsp_valid != 0, else 8'h00
//   busy       out 1      FSM not idle
//   rand_now   out 8      current LFSR state
// Optional feature macro: RAND_SEED_EN (seed load ports).
// -----------------------------------------------------------------------------
module rand_req_arbiter
    import tank_pkg::*;
#(
    parameter int N_REQ = 4,
    parameter int STEPS = 8
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [N_REQ-1:0]  req,
`ifdef RAND_SEED_EN
    input  logic              seed_load,
    input  logic [RAND_W-1:0] seed,
`endif
    output logic [N_REQ-1:0]  rsp_valid,
    output logic [RAND_W-1:0] rsp_data,
    output logic              busy,
    output logic [RAND_W-1:0] rand_now
);

    localparam int IDX_W = $clog2(N_REQ);
    localparam logic [7:0] CNT_INIT = 8'(STEPS - 1);
    localparam logic [N_REQ-1:0] ONE_HOT0 = {{(N_REQ-1){1'b0}}, 1'b1};
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_REQ - 1);

    ra_state_t         state_r;
    logic [7:0]        cnt_r;
    logic [IDX_W-1:0]  winner_r;
    logic [IDX_W-1:0]  rr_ptr_r;
    logic [N_REQ-1:0]  rsp_valid_r;
    logic [RAND_W-1:0] rsp_data_r;
    logic              busy_r;

    logic              win_found_s;
    logic [IDX_W-1:0]  win_idx_s;
    logic              load_s;
    logic [RAND_W-1:0] load_val_s;
    logic [RAND_W-1:0] lfsr_q_s;
    logic [RAND_W-1:0] lfsr_d_s;

`ifdef RAND_SEED_EN
    assign load_s     = seed_load;
    assign load_val_s = seed;
`else
    assign load_s     = 1'b0;
    assign load_val_s = {RAND_W{1'b0}};
`endif

    lfsr_step8 u_lfsr (
        .Clk      (Clk),
        .Reset_n  (Reset_n),
        .load     (load_s),
        .load_val (load_val_s),
        .q        (lfsr_q_s)
    );

    // LFSR value that will be visible in the cycle after this edge; the
    // response byte is registered from it so rsp_data equals rand_now in
    // the GRANT cycle.
    always_comb begin
        lfsr_d_s = lfsr_d(load_s, load_val_s, lfsr_q_s);
    end

    // Round-robin scan: first set request at or above rr_ptr, wrapping.
    always_comb begin
        int idx_v;
        idx_v       = 0;
        win_found_s = 1'b0;
        win_idx_s   = {IDX_W{1'b0}};
        for (int i = 0; i < N_REQ; i++) begin
            idx_v = int'(rr_ptr_r) + i;
            if (idx_v >= N_REQ) begin
                idx_v = idx_v - N_REQ;
            end else begin
                idx_v = idx_v;
            end
            if (!win_found_s && req[IDX_W'(idx_v)]) begin
                win_found_s = 1'b1;
                win_idx_s   = IDX_W'(idx_v);
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Arbiter FSM with registered outputs (rsp_valid/rsp_data/busy).
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_r     <= RA_IDLE;
            cnt_r       <= 8'h00;
            winner_r    <= {IDX_W{1'b0}};
            rr_ptr_r    <= {IDX_W{1'b0}};
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_data_r  <= {RAND_W{1'b0}};
            busy_r      <= 1'b0;
        end else begin
            rsp_valid_r <= {N_REQ{1'b0}};
            rsp_data_r  <= {RAND_W{1'b0}};
            case (state_r)
                RA_IDLE: begin
                    if (win_found_s) begin
                        winner_r <= win_idx_s;
                        cnt_r    <= CNT_INIT;
                        state_r  <= RA_WAIT;
                        busy_r   <= 1'b1;
                    end else begin
                        state_r  <= RA_IDLE;
                        busy_r   <= 1'b0;
                    end
                end
                RA_WAIT: begin
                    if (!req[winner_r]) begin
                        // Winner withdrew: abandon without moving rr_ptr.
                        state_r <= RA_IDLE;
                        busy_r  <= 1'b0;
                    end else if (cnt_r == 8'h00) begin
                        state_r     <= RA_GRANT;
                        busy_r      <= 1'b1;
                        rsp_valid_r <= ONE_HOT0 << winner_r;
                        rsp_data_r  <= lfsr_d_s;
                    end else begin
                        cnt_r  <= cnt_r - 8'h01;
                        busy_r <= 1'b1;
                    end
                end
                RA_GRANT: begin
                    state_r <= RA_IDLE;
                    busy_r  <= 1'b0;
                    if (winner_r == LAST_IDX) begin
                        rr_ptr_r <= {IDX_W{1'b0}};
                    end else begin
                        rr_ptr_r <= winner_r + 1'b1;
                    end
                end
                default: begin
                    state_r  <= RA_IDLE;
                    cnt_r    <= 8'h00;
                    busy_r   <= 1'b0;
                    rr_ptr_r <= {IDX_W{1'b0}};
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign busy      = busy_r;
    assign rand_now  = lfsr_q_s;

endmodule

// File: tb/tb_rand_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_rand_req_arbiter
// Directed bench for rand_req_arbiter (N_REQ=4, STEPS=8). Expected grants are
// queued when requests are driven and compared when responses appear; an
// independent LFSR model supplies expected random values.
// -----------------------------------------------------------------------------
module tb_rand_req_arbiter;

    localparam int N     = 4;
    localparam int STEPS = 8;

    typedef struct {
        logic [N-1:0] vec;
        int           due;
    } exp_t;

    logic         Clk;
    logic         Reset_n;
    logic [N-1:0] req;
    logic [N-1:0] rsp_valid;
    logic [7:0]   rsp_data;
    logic         busy;
    logic [7:0]   rand_now;
`ifdef RAND_SEED_EN
    logic         seed_load;
    logic [7:0]   seed;
`endif

    exp_t sb[$];
    int   cyc_n;
    int   n_checks;
    int   n_pass;
    int   n_fail;
    bit   auto_drop;
    bit   busy_force;
    bit   busy_val;
    logic [7:0] m_lfsr;
    logic [7:0] seq_tbl [8];

    rand_req_arbiter #(.N_REQ(N), .STEPS(STEPS)) dut (
        .Clk       (Clk),
        .Reset_n   (Reset_n),
        .req       (req),
`ifdef RAND_SEED_EN
        .seed_load (seed_load),
        .seed      (seed),
`endif
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .busy      (busy),
        .rand_now  (rand_now)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Reference LFSR model: XNOR of bits 7 and 2 shifted in at bit 0.
    always @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            m_lfsr <= 8'h00;
        end else begin
`ifdef RAND_SEED_EN
            if (seed_load) m_lfsr <= (seed == 8'hFF) ? 8'h00 : seed;
            else           m_lfsr <= {m_lfsr[6:0], ~(m_lfsr[7] ^ m_lfsr[2])};
`else
            m_lfsr <= {m_lfsr[6:0], ~(m_lfsr[7] ^ m_lfsr[2])};
`endif
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed 'h%0h expected 'h%0h (cycle %0d)", tag, obs, exp, cyc_n);
        end
    endtask

    task automatic push(input logic [N-1:0] vec, input int due);
        exp_t e;
        e.vec = vec;
        e.due = due;
        sb.push_back(e);
    endtask

    // One clock: advance, then sample on the falling edge and score.
    task automatic cyc();
        logic [N-1:0] exp_v;
        logic [7:0]   exp_d;
        logic         eb;
        bit           hit;
        @(posedge Clk);
        cyc_n++;
        @(negedge Clk);
        exp_v = '0;
        exp_d = 8'h00;
        hit   = 1'b0;
        if (sb.size() > 0 && sb[0].due == cyc_n) begin
            exp_v = sb[0].vec;
            exp_d = m_lfsr;
            hit   = 1'b1;
        end
        if (busy_force) eb = busy_val;
        else eb = (sb.size() > 0) && (cyc_n + STEPS >= sb[0].due) && (cyc_n <= sb[0].due);
        chk("rand_now", 32'(rand_now), 32'(m_lfsr));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_v));
        chk("rsp_data", 32'(rsp_data), 32'(exp_d));
        chk("busy", 32'(busy), 32'(eb));
        if (hit) begin
            void'(sb.pop_front());
            if (auto_drop) req = req & ~exp_v;
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, 32'(rsp_valid), 32'h0);
        chk({tag, "_rsp_data"},  32'(rsp_data),  32'h0);
        chk({tag, "_busy"},      32'(busy),      32'h0);
        chk({tag, "_rand_now"},  32'(rand_now),  32'h0);
    endtask

    initial begin
        seq_tbl = '{8'h00, 8'h01, 8'h03, 8'h07, 8'h0E, 8'h1C, 8'h38, 8'h71};
        n_checks   = 0;
        n_pass     = 0;
        n_fail     = 0;
        cyc_n      = 0;
        auto_drop  = 1'b1;
        busy_force = 1'b0;
        busy_val   = 1'b0;
        req        = '0;
        Reset_n    = 1'b0;
`ifdef RAND_SEED_EN
        seed_load  = 1'b0;
        seed       = 8'h00;
`endif
        repeat (2) @(negedge Clk);
        chk_reset_outputs("in_reset");

        // 1. LFSR sequence from reset release, no requests
        Reset_n = 1'b1;
        #1;
        chk("lfsr_seq0", 32'(rand_now), 32'(seq_tbl[0]));
        for (int i = 1; i < 8; i++) begin
            cyc();
            chk("lfsr_seq", 32'(rand_now), 32'(seq_tbl[i]));
        end

        // 2. single request from requester 0, latency STEPS+1
        req = 4'b0001;
        push(4'b0001, cyc_n + STEPS + 1);
        repeat (STEPS + 4) cyc();

        // 3. all four requesting after reset: order 0,1,2,3
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_before_t3");
        #1;
        Reset_n = 1'b1;
        req = 4'b1111;
        push(4'b0001, cyc_n + STEPS + 1);
        push(4'b0010, cyc_n + 2 * STEPS + 3);
        push(4'b0100, cyc_n + 3 * STEPS + 5);
        push(4'b1000, cyc_n + 4 * STEPS + 7);
        repeat (4 * STEPS + 10) cyc();
        chk("t3_req_all_dropped", 32'(req), 32'h0);

        // 4. serve 2 so rr_ptr=3, then 4'b1001 wraps: 3 first, then 0
        req = 4'b0100;
        push(4'b0100, cyc_n + STEPS + 1);
        repeat (STEPS + 3) cyc();
        req = 4'b1001;
        push(4'b1000, cyc_n + STEPS + 1);
        push(4'b0001, cyc_n + 2 * STEPS + 3);
        repeat (2 * STEPS + 5) cyc();

        // 5a. winner (2) withdraws mid-WAIT: abandon, rr_ptr stays at 1
        req = 4'b1100;
        busy_force = 1'b1;
        busy_val   = 1'b1;
        repeat (4) cyc();
        req      = 4'b0000;
        busy_val = 1'b0;
        repeat (4) cyc();
        busy_force = 1'b0;
        req = 4'b1100;
        push(4'b0100, cyc_n + STEPS + 1);
        push(4'b1000, cyc_n + 2 * STEPS + 3);
        repeat (2 * STEPS + 5) cyc();

        // 5b. reset asserted mid-WAIT: outputs clear at once, grant lost
        req = 4'b0001;
        busy_force = 1'b1;
        busy_val   = 1'b1;
        repeat (3) cyc();
        Reset_n = 1'b0;
        #1;
        chk_reset_outputs("rst_mid_wait");
        req = 4'b0000;
        #1;
        Reset_n    = 1'b1;
        busy_force = 1'b0;
        repeat (STEPS + 4) cyc();
        // after reset rr_ptr is 0: 4'b0110 goes to 1 first
        req = 4'b0110;
        push(4'b0010, cyc_n + STEPS + 1);
        push(4'b0100, cyc_n + 2 * STEPS + 3);
        repeat (2 * STEPS + 5) cyc();

`ifdef RAND_SEED_EN
        // 6. seed load, then lock-up seed replaced by zero
        seed_load = 1'b1;
        seed      = 8'hA5;
        cyc();
        chk("seed_a5", 32'(rand_now), 32'hA5);
        seed_load = 1'b0;
        cyc();
        chk("seed_a5_step", 32'(rand_now), 32'h4B);
        seed_load = 1'b1;
        seed      = 8'hFF;
        cyc();
        chk("seed_ff_guard", 32'(rand_now), 32'h00);
        seed_load = 1'b0;
        cyc();
`endif

        chk("sb_empty", 32'(sb.size()), 32'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
